// File: rtl/vram_pkg.sv
// Shared constants, data types and fill FSM states for the VRAM write
// arbiter. Optional vblank-only fill gating: VRAM_FILL_VBLANK_ONLY_EN.
package vram_pkg;

  localparam int VRAM_COLS   = 60;
  localparam int VRAM_ROWS   = 17;
  localparam int VRAM_CELLS  = VRAM_COLS * VRAM_ROWS;
  localparam int VRAM_ADDR_W = 10;
  localparam int VRAM_DATA_W = 8;

  typedef logic [VRAM_ADDR_W-1:0] vram_addr_t;
  typedef logic [VRAM_DATA_W-1:0] vram_data_t;

  typedef enum logic [1:0] {
    F_IDLE,
    F_RUN,
    F_DONE
  } fill_state_t;

endpackage

// File: rtl/vram_fill_seq.sv
// Screen fill sequencer: walks the pointer over every text cell,
// offering one write slot per cycle while the gate is open.
module vram_fill_seq
  import vram_pkg::*;
#(
  parameter int CELLS  = VRAM_CELLS,
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DATA_W-1:0] char_i,
  input  logic              gate_i,
  input  logic              grant_i,
  output logic              want_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(CELLS - 1);

  fill_state_t       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] char_q, char_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    char_d  = char_q;
    unique case (state_q)
      F_IDLE: begin
        if (start_i) begin
          char_d  = char_i;
          ptr_d   = '0;
          state_d = F_RUN;
        end
      end
      F_RUN: begin
        if (grant_i) begin
          if (ptr_q == LAST) state_d = F_DONE;
          else ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      F_DONE:  state_d = F_IDLE;
      default: state_d = F_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= F_IDLE;
      ptr_q   <= '0;
      char_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      char_q  <= char_d;
    end
  end

  assign want_o = (state_q == F_RUN) && gate_i;
  assign addr_o = ptr_q;
  assign data_o = char_q;
  assign busy_o = (state_q == F_RUN);
  assign done_o = (state_q == F_DONE);

endmodule

// File: rtl/vram_write_arbiter.sv
// VRAM port A owner: CPU byte writes with strict priority over the fill
// engine. VRAM_FILL_VBLANK_ONLY_EN restricts fill writes to vblank.
module vram_write_arbiter
  import vram_pkg::*;
#(
  parameter int CELLS  = VRAM_CELLS,
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              cpu_ack,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_char,
  output logic              fill_busy,
  output logic              fill_done,
  input  logic              vsync,
  output logic [ADDR_W-1:0] v_ada,
  output logic [DATA_W-1:0] v_din,
  output logic              v_cea
);

  logic              cpu_ack_q, cpu_ack_d;
  logic              done_q, done_d;
  logic              cea_q, cea_d;
  logic [ADDR_W-1:0] ada_q, ada_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              vs_meta_q, vs_meta_d;
  logic              vs_sync_q, vs_sync_d;

  logic              cpu_sel, fill_grant, gate;
  logic              fill_want, seq_busy, seq_done;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_data;

`ifdef VRAM_FILL_VBLANK_ONLY_EN
  assign gate = vs_sync_q;
`else
  assign gate = vs_sync_q | 1'b1;
`endif

  vram_fill_seq #(
    .CELLS  (CELLS),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_seq (
    .clk     (clk),
    .rst     (rst),
    .start_i (fill_start),
    .char_i  (fill_char),
    .gate_i  (gate),
    .grant_i (fill_grant),
    .want_o  (fill_want),
    .addr_o  (fill_addr),
    .data_o  (fill_data),
    .busy_o  (seq_busy),
    .done_o  (seq_done)
  );

  // The ack cycle masks the request, leaving a gap the fill always wins.
  assign cpu_sel    = cpu_req & ~cpu_ack_q;
  assign fill_grant = fill_want & ~cpu_sel;

  always_comb begin
    cpu_ack_d = cpu_sel;
    done_d    = seq_done;
    cea_d     = cpu_sel | fill_grant;
    ada_d     = ada_q;
    din_d     = din_q;
    vs_meta_d = vsync;
    vs_sync_d = vs_meta_q;
    if (cpu_sel) begin
      ada_d = cpu_addr;
      din_d = cpu_data;
    end else if (fill_grant) begin
      ada_d = fill_addr;
      din_d = fill_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_ack_q <= 1'b0;
      done_q    <= 1'b0;
      cea_q     <= 1'b0;
      ada_q     <= '0;
      din_q     <= '0;
      vs_meta_q <= 1'b0;
      vs_sync_q <= 1'b0;
    end else begin
      cpu_ack_q <= cpu_ack_d;
      done_q    <= done_d;
      cea_q     <= cea_d;
      ada_q     <= ada_d;
      din_q     <= din_d;
      vs_meta_q <= vs_meta_d;
      vs_sync_q <= vs_sync_d;
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign fill_done = done_q;
  assign fill_busy = seq_busy;
  assign v_cea     = cea_q;
  assign v_ada     = ada_q;
  assign v_din     = din_q;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed bench for vram_write_arbiter: reset, CPU writes, fills,
// contention and ignored restarts; vblank gating when enabled.
module tb_vram_write_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_req = 1'b0;
  logic [9:0] cpu_addr = '0;
  logic [7:0] cpu_data = '0;
  logic       fill_start = 1'b0;
  logic [7:0] fill_char = '0;
  logic       vsync = 1'b1;
  logic       cpu_ack, fill_busy, fill_done, v_cea;
  logic [9:0] v_ada;
  logic [7:0] v_din;

  vram_write_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_data   (cpu_data),
    .cpu_ack    (cpu_ack),
    .fill_start (fill_start),
    .fill_char  (fill_char),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .vsync      (vsync),
    .v_ada      (v_ada),
    .v_din      (v_din),
    .v_cea      (v_cea)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs = 0;
  int checks = 0;

  logic [9:0] wa[$];
  logic [7:0] wd[$];
  int         wc[$];
  int         ack_n, ack_cyc, done_n, done_cyc;
  logic [7:0] mem [0:1023];

  always @(negedge clk) begin
    if (v_cea) begin
      wa.push_back(v_ada);
      wd.push_back(v_din);
      wc.push_back(cyc);
      mem[v_ada] = v_din;
    end
    if (cpu_ack) begin
      ack_n++;
      ack_cyc = cyc;
    end
    if (fill_done) begin
      done_n++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_log();
    wa.delete();
    wd.delete();
    wc.delete();
    ack_n  = 0;
    done_n = 0;
  endtask

  task automatic wait_done(input int lim, output bit ok);
    int n0 = done_n;
    int k = 0;
    while (done_n == n0 && k < lim) begin
      tick();
      k++;
    end
    ok = (done_n != n0);
  endtask

  // Fill entries must be exactly 0..1019 in order with one char.
  task automatic check_fill(input string tag, input logic [7:0] ch);
    int k = 0;
    int bad = 0;
    foreach (wa[i]) begin
      if (wa[i] != 10'h3FF) begin
        if (wa[i] != 10'(k) || wd[i] != ch) bad++;
        k++;
      end
    end
    chk({tag, "_cnt"}, k, 1020);
    chk({tag, "_order"}, bad, 0);
  endtask

  initial begin
    int  c0, nc, bad, first, lastf;
    bit  ok;
    tick(3);
    rst = 1'b0;
    tick(2);

    // Reset mid-fill with a pending CPU request
    fill_char  = 8'h11;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    tick(40);
    cpu_addr = 10'h155;
    cpu_data = 8'h77;
    cpu_req  = 1'b1;
    rst      = 1'b1;
    tick();
    chk("rst_cea", v_cea, 0);
    chk("rst_ack", cpu_ack, 0);
    chk("rst_busy", fill_busy, 0);
    chk("rst_done", fill_done, 0);
    chk("rst_ada", v_ada, 0);
    chk("rst_din", v_din, 0);
    tick(2);
    rst     = 1'b0;
    cpu_req = 1'b0;
    clr_log();
    tick(20);
    chk("rst_abort_done", done_n, 0);
    chk("rst_abort_wr", wa.size(), 0);
    chk("rst_abort_busy", fill_busy, 0);

    // Single CPU write, req held through the ack cycle
    clr_log();
    c0       = cyc;
    cpu_addr = 10'h03C;
    cpu_data = 8'h41;
    cpu_req  = 1'b1;
    tick(2);
    cpu_req = 1'b0;
    tick(5);
    chk("cpu_nwr", wa.size(), 1);
    chk("cpu_addr", (wa.size() > 0) ? wa[0] : 10'h000, 10'h03C);
    chk("cpu_data", (wd.size() > 0) ? wd[0] : 8'h00, 8'h41);
    chk("cpu_nack", ack_n, 1);
    chk("cpu_ack_cyc", ack_cyc, c0 + 1);

    // Fill alone
    clr_log();
    c0         = cyc;
    fill_char  = 8'h20;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    chk("fa_busy", fill_busy, 1);
    wait_done(1100, ok);
    chk("fa_done_seen", ok, 1);
    check_fill("fa", 8'h20);
    first = (wc.size() > 0) ? wc[0] : -1;
    lastf = (wc.size() > 0) ? wc[$] : -1;
    chk("fa_first", first, c0 + 2);
    chk("fa_span", lastf - first, 1019);
    chk("fa_done_cyc", done_cyc, lastf + 1);
    tick();
    chk("fa_busy_end", fill_busy, 0);
    chk("fa_ndone", done_n, 1);

    // Second start while busy is ignored
    clr_log();
    fill_char  = 8'h5A;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    tick(10);
    fill_char  = 8'h2E;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    wait_done(1100, ok);
    tick(3);
    chk("ig_done_seen", ok, 1);
    check_fill("ig", 8'h5A);
    bad = 0;
    for (int a = 0; a < 1020; a++) if (mem[a] !== 8'h5A) bad++;
    chk("ig_mem", bad, 0);
    chk("ig_ndone", done_n, 1);

    // Contention: continuous CPU req plus fill started the same cycle
    clr_log();
    c0         = cyc;
    fill_char  = 8'h2A;
    fill_start = 1'b1;
    cpu_addr   = 10'h3FF;
    cpu_data   = 8'h99;
    cpu_req    = 1'b1;
    tick();
    fill_start = 1'b0;
    wait_done(2100, ok);
    cpu_req = 1'b0;
    tick(3);
    chk("ct_done_seen", ok, 1);
    check_fill("ct", 8'h2A);
    nc = 0;
    bad = 0;
    first = -1;
    lastf = -1;
    foreach (wa[i]) begin
      if (wa[i] == 10'h3FF) begin
        nc++;
        if (wd[i] != 8'h99) bad++;
      end else begin
        if (first < 0) first = wc[i];
        lastf = wc[i];
        if (i > 0 && wa[i-1] != 10'h3FF && wc[i-1] == wc[i] - 1) bad++;
      end
    end
    chk("ct_cpu_or_alt", bad, 0);
    chk("ct_cpu_many", nc >= 1020, 1);
    chk("ct_nack", ack_n, nc);
    chk("ct_first_fill", first, c0 + 2);
    chk("ct_bound", (lastf - c0) <= 2040, 1);
    chk("ct_mem3ff", mem[10'h3FF], 8'h99);

`ifdef VRAM_FILL_VBLANK_ONLY_EN
    // Fill parked during active video, CPU still served
    vsync = 1'b0;
    tick(3);
    clr_log();
    fill_char  = 8'h33;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    tick(100);
    cpu_addr = 10'h010;
    cpu_data = 8'h55;
    cpu_req  = 1'b1;
    tick(2);
    cpu_req = 1'b0;
    tick(398);
    nc = 0;
    foreach (wa[i]) if (wd[i] == 8'h33) nc++;
    chk("vb_no_fill", nc, 0);
    chk("vb_cpu_ack", ack_n, 1);
    c0    = cyc;
    vsync = 1'b1;
    wait_done(1200, ok);
    chk("vb_done_seen", ok, 1);
    first = -1;
    foreach (wa[i]) if (first < 0 && wd[i] == 8'h33) first = wc[i];
    chk("vb_resume", (first - c0) >= 2 && (first - c0) <= 3, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
